// File: rtl/axil_reg_responder.sv
// AXI4-Lite responder backed by a small byte-strobed register array.
// Write and read channels are independent; out-of-range addresses complete with DECERR.
module axil_reg_responder #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 16,
  parameter int STRB_WIDTH      = DATA_WIDTH / 8,
  parameter int REG_COUNT_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready
);

  localparam int BYTE_LSB   = $clog2(STRB_WIDTH);
  localparam int IDX_HI     = REG_COUNT_WIDTH + BYTE_LSB;
  localparam int WORD_COUNT = 1 << REG_COUNT_WIDTH;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;

  logic [DATA_WIDTH-1:0]      regs [WORD_COUNT];
  w_state_t                   w_state, w_state_next;
  logic                       w_accept;
  logic [REG_COUNT_WIDTH-1:0] w_idx, r_idx;
  logic                       w_in_range, r_in_range;
  logic                       ar_hs;
  logic                       unused_inputs;

  assign w_idx      = s_axil_awaddr[IDX_HI-1:BYTE_LSB];
  assign r_idx      = s_axil_araddr[IDX_HI-1:BYTE_LSB];
  assign w_in_range = (s_axil_awaddr[ADDR_WIDTH-1:IDX_HI] == '0);
  assign r_in_range = (s_axil_araddr[ADDR_WIDTH-1:IDX_HI] == '0);

  // Protection bits and byte-offset bits carry no meaning for this register store.
  assign unused_inputs = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr, s_axil_araddr};

  // ---------------- write channel FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) w_state <= W_IDLE;
    else      w_state <= w_state_next;
  end

  always_comb begin
    w_state_next = w_state;
    case (w_state)
      W_IDLE:  if (w_accept) w_state_next = W_RESP;
      W_RESP:  if (s_axil_bready && !w_accept) w_state_next = W_IDLE;
      default: w_state_next = W_IDLE;
    endcase
  end

  // A pending response that is being retired this cycle frees the slot for a new AW/W pair.
  always_comb begin
    // NOTE: every output gets a default first so no path through the block infers a latch.
    s_axil_awready = 1'b0;
    s_axil_wready  = 1'b0;
    w_accept       = 1'b0;
    s_axil_bvalid  = (w_state == W_RESP);
    if (rst && s_axil_awvalid && s_axil_wvalid && (w_state == W_IDLE || s_axil_bready)) begin
      s_axil_awready = 1'b1;
      s_axil_wready  = 1'b1;
      w_accept       = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          s_axil_bresp <= RESP_OKAY;
    else if (w_accept) s_axil_bresp <= w_in_range ? RESP_OKAY : RESP_DECERR;
  end

  // ---------------- register array ----------------
  // NOTE: the array is reset because software may read any word straight after reset and
  // must see zero; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < WORD_COUNT; i++) regs[i] <= '0;
    end else if (w_accept && w_in_range) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (s_axil_wstrb[b]) regs[w_idx][b*8 +: 8] <= s_axil_wdata[b*8 +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  assign s_axil_arready = rst && (!s_axil_rvalid || s_axil_rready);
  assign ar_hs          = s_axil_arvalid && s_axil_arready;

  // NOTE: non-blocking updates mean a read accepted alongside a write to the same word
  // samples the pre-write contents.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_axil_rvalid <= 1'b0;
      s_axil_rdata  <= '0;
      s_axil_rresp  <= RESP_OKAY;
    end else if (ar_hs) begin
      s_axil_rvalid <= 1'b1;
      s_axil_rdata  <= r_in_range ? regs[r_idx] : '0;
      s_axil_rresp  <= r_in_range ? RESP_OKAY : RESP_DECERR;
    end else if (s_axil_rready) begin
      s_axil_rvalid <= 1'b0;
    end
  end

endmodule
